// File: rtl/busy_timer_bank_if.sv
// rtl/busy_timer_bank_if.sv - start/abort/config and status bundle for busy_timer_bank
interface busy_timer_bank_if #(
    parameter int NCH = 4,
    parameter int CW  = 16
);
    logic [NCH-1:0] i_start;
    logic [NCH-1:0] i_abort;
    logic           i_cfg_we;
    logic [3:0]     i_cfg_ch;
    logic [CW-1:0]  i_cfg_amount;
    logic [1:0]     i_cfg_mode;
    logic [NCH-1:0] o_busy;
    logic [NCH-1:0] o_done;
    logic           o_any_busy;

    modport master (
        output i_start, i_abort, i_cfg_we, i_cfg_ch, i_cfg_amount, i_cfg_mode,
        input  o_busy, o_done, o_any_busy
    );

    modport slave (
        input  i_start, i_abort, i_cfg_we, i_cfg_ch, i_cfg_amount, i_cfg_mode,
        output o_busy, o_done, o_any_busy
    );
endinterface

// File: rtl/busy_timer_bank.sv
// rtl/busy_timer_bank.sv - bank of independent busy-window timers with oneshot/retrigger/periodic modes
module busy_timer_bank #(
    parameter int            NCH            = 4,
    parameter int            CW             = 16,
    parameter logic [CW-1:0] DEFAULT_AMOUNT = CW'(22)
) (
    input logic             i_clk,
    input logic             i_reset_n,
    busy_timer_bank_if.slave bus
);
    localparam logic [1:0] MODE_ONESHOT  = 2'd0;
    localparam logic [1:0] MODE_RETRIG   = 2'd1;
    localparam logic [1:0] MODE_PERIODIC = 2'd2;

    logic [NCH-1:0] busy_vec;
    logic [NCH-1:0] done_vec;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [CW-1:0] cnt, cnt_nxt;
        logic [CW-1:0] amt;
        logic [1:0]    mode;
        logic          done_q, done_nxt;
        logic          cfg_hit;
        logic          reload;

        // Matching against k also rejects channel numbers at or above NCH.
        assign cfg_hit = bus.i_cfg_we && (bus.i_cfg_ch == 4'(k));
        assign reload  = (cnt != '0) && (mode == MODE_RETRIG) && bus.i_start[k] && (amt != '0);

        always_comb begin
            cnt_nxt  = cnt;
            done_nxt = 1'b0;
            if (bus.i_abort[k]) begin
                cnt_nxt = '0;
            end else if (cnt == '0) begin
                if (bus.i_start[k] && (amt != '0)) cnt_nxt = amt;
            end else if (reload) begin
                // Retrigger at cnt==1 swallows the expiry pulse as well.
                cnt_nxt = amt;
            end else if (cnt == CW'(1)) begin
                done_nxt = 1'b1;
                cnt_nxt  = (mode == MODE_PERIODIC) ? amt : '0;
            end else begin
                cnt_nxt = cnt - CW'(1);
            end
        end

        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                cnt    <= '0;
                done_q <= 1'b0;
                amt    <= DEFAULT_AMOUNT;
                mode   <= MODE_ONESHOT;
            end else begin
                cnt    <= cnt_nxt;
                done_q <= done_nxt;
                if (cfg_hit) begin
                    amt  <= bus.i_cfg_amount;
                    mode <= bus.i_cfg_mode;
                end
            end
        end

        assign busy_vec[k] = (cnt != '0);
        assign done_vec[k] = done_q;

`ifdef FORMAL
        a_busy: assert property (@(posedge i_clk) disable iff (!i_reset_n)
            (cnt != '0) |-> busy_vec[k]);
        a_dec: assert property (@(posedge i_clk) disable iff (!i_reset_n)
            ((cnt > CW'(1)) && !bus.i_abort[k] && !reload) |=> (cnt == $past(cnt) - CW'(1)));
        a_done: assert property (@(posedge i_clk) disable iff (!i_reset_n)
            (done_q && (mode == MODE_ONESHOT) && ($past(mode) == MODE_ONESHOT)) |=> !done_q);
`endif
    end

    assign bus.o_busy     = busy_vec;
    assign bus.o_done     = done_vec;
    assign bus.o_any_busy = |busy_vec;
endmodule

// File: tb/tb_busy_timer_bank.sv
// tb/tb_busy_timer_bank.sv - scoreboard bench for busy_timer_bank
module tb_busy_timer_bank;
    localparam int NCH = 4;
    localparam int CW  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    busy_timer_bank_if #(.NCH(NCH), .CW(CW)) bus ();

    busy_timer_bank #(.NCH(NCH), .CW(CW), .DEFAULT_AMOUNT(16'd22)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    typedef struct {
        int       tag;
        int       idx;
        logic [3:0] b;
        logic [3:0] d;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   tag    = 0;
    int   idx    = 0;
    event mon_ev;

    always @(posedge clk) begin
        #2;
        ->mon_ev;
    end

    initial begin
        exp_t e;
        forever begin
            @(mon_ev);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (bus.o_busy !== e.b) begin
                    errors++;
                    $display("FAIL busy tag=%0d idx=%0d got=%b want=%b", e.tag, e.idx, bus.o_busy, e.b);
                end
                checks++;
                if (bus.o_done !== e.d) begin
                    errors++;
                    $display("FAIL done tag=%0d idx=%0d got=%b want=%b", e.tag, e.idx, bus.o_done, e.d);
                end
                checks++;
                if (bus.o_any_busy !== (|e.b)) begin
                    errors++;
                    $display("FAIL any_busy tag=%0d idx=%0d got=%b want=%b", e.tag, e.idx, bus.o_any_busy, |e.b);
                end
            end
        end
    end

    task automatic expect_now(input logic [3:0] eb, input logic [3:0] ed);
        q.push_back('{tag, idx, eb, ed});
        idx++;
    endtask

    task automatic tick(input logic [3:0] st, input logic [3:0] ab,
                        input logic [3:0] eb, input logic [3:0] ed);
        bus.i_start = st;
        bus.i_abort = ab;
        expect_now(eb, ed);
        @(negedge clk);
        bus.i_cfg_we = 1'b0;
        bus.i_start  = '0;
        bus.i_abort  = '0;
    endtask

    task automatic cfg(input logic [3:0] ch, input logic [15:0] amt, input logic [1:0] mode);
        bus.i_cfg_we     = 1'b1;
        bus.i_cfg_ch     = ch;
        bus.i_cfg_amount = amt;
        bus.i_cfg_mode   = mode;
    endtask

    task automatic new_test(input int t);
        tag = t;
        idx = 0;
    endtask

    initial begin
        bus.i_start      = '0;
        bus.i_abort      = '0;
        bus.i_cfg_we     = 1'b0;
        bus.i_cfg_ch     = '0;
        bus.i_cfg_amount = '0;
        bus.i_cfg_mode   = '0;

        // reset state
        new_test(0);
        @(negedge clk);
        @(negedge clk);
        expect_now(4'b0000, 4'b0000);
        ->mon_ev;
        rst_n = 1'b1;
        tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // ch0 default amount 22: busy 22 cycles, done on the 23rd
        new_test(1);
        tick(4'b0001, 4'b0000, 4'b0001, 4'b0000);
        for (int i = 0; i < 21; i++) tick(4'b0000, 4'b0000, 4'b0001, 4'b0000);
        tick(4'b0000, 4'b0000, 4'b0000, 4'b0001);
        tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // ch1 retrigger amt 5, restart at t3 -> 8 busy cycles, one done
        new_test(2);
        cfg(4'd1, 16'd5, 2'd1);
        tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick(4'b0010, 4'b0000, 4'b0010, 4'b0000);
        tick(4'b0000, 4'b0000, 4'b0010, 4'b0000);
        tick(4'b0000, 4'b0000, 4'b0010, 4'b0000);
        tick(4'b0010, 4'b0000, 4'b0010, 4'b0000);
        for (int i = 0; i < 4; i++) tick(4'b0000, 4'b0000, 4'b0010, 4'b0000);
        tick(4'b0000, 4'b0000, 4'b0000, 4'b0010);
        tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // ch2 periodic amt 4: continuous busy, done every 4, abort ends it quietly
        new_test(3);
        cfg(4'd2, 16'd4, 2'd2);
        tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick(4'b0100, 4'b0000, 4'b0100, 4'b0000);
        for (int i = 1; i <= 12; i++)
            tick(4'b0000, 4'b0000, 4'b0100, (i % 4 == 0) ? 4'b0100 : 4'b0000);
        tick(4'b0000, 4'b0100, 4'b0000, 4'b0000);
        tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // ch3 oneshot and reserved mode: restart while busy is ignored
        for (int m = 0; m < 4; m += 3) begin
            new_test(4 + m);
            cfg(4'd3, 16'd3, m[1:0]);
            tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);
            tick(4'b1000, 4'b0000, 4'b1000, 4'b0000);
            tick(4'b1000, 4'b0000, 4'b1000, 4'b0000);
            tick(4'b0000, 4'b0000, 4'b1000, 4'b0000);
            tick(4'b0000, 4'b0000, 4'b0000, 4'b1000);
            tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end

        // amount 0 start is ignored
        new_test(8);
        cfg(4'd3, 16'd0, 2'd0);
        tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick(4'b1000, 4'b0000, 4'b0000, 4'b0000);
        tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // write to channel 7 must not land on any channel
        new_test(9);
        cfg(4'd7, 16'd1, 2'd2);
        tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick(4'b1000, 4'b0000, 4'b0000, 4'b0000);
        tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // abort beats start on an idle channel
        new_test(10);
        tick(4'b0001, 4'b0001, 4'b0000, 4'b0000);
        tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // start coincident with config write uses the old amount (5) and mode (retrigger)
        new_test(11);
        cfg(4'd1, 16'd2, 2'd0);
        tick(4'b0010, 4'b0000, 4'b0010, 4'b0000);
        tick(4'b0010, 4'b0000, 4'b0010, 4'b0000);
        for (int i = 0; i < 3; i++) tick(4'b0000, 4'b0000, 4'b0010, 4'b0000);
        tick(4'b0000, 4'b0000, 4'b0000, 4'b0010);
        tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // reset asserted with ch0 at cnt=10 clears outputs immediately
        new_test(12);
        tick(4'b0001, 4'b0000, 4'b0001, 4'b0000);
        for (int i = 0; i < 12; i++) tick(4'b0000, 4'b0000, 4'b0001, 4'b0000);
        rst_n = 1'b0;
        #1;
        expect_now(4'b0000, 4'b0000);
        ->mon_ev;
        @(negedge clk);
        rst_n = 1'b1;

        // after reset ch3 is back to the default amount
        new_test(13);
        tick(4'b1000, 4'b0000, 4'b1000, 4'b0000);
        tick(4'b0000, 4'b0000, 4'b1000, 4'b0000);
        tick(4'b0000, 4'b1000, 4'b0000, 4'b0000);
        tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending want=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/busy_timer_bank.md
BUSY_TIMER_BANK -- requirements
Module: busy_timer_bank

Interface
REQ-001 The block SHALL have parameter NCH, default 4, meaning the number of independent timer channels (1..16).
REQ-002 The block SHALL have parameter CW, default 16, meaning the counter and amount width in bits.
REQ-003 The block SHALL have parameter [CW-1:0] DEFAULT_AMOUNT, default 22, meaning the per-channel amount after reset.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port i_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port i_start, input, NCH bits: per-channel start request, level-sampled each cycle.
REQ-007 The block SHALL have port i_abort, input, NCH bits: per-channel abort request.
REQ-008 The block SHALL have port i_cfg_we, input, 1 bit: configuration write strobe.
REQ-009 The block SHALL have port i_cfg_ch, input, 4 bits: target channel of the configuration write.
REQ-010 The block SHALL have port i_cfg_amount, input, CW bits: new busy duration in cycles.
REQ-011 The block SHALL have port i_cfg_mode, input, 2 bits: new mode (0 ONESHOT, 1 RETRIGGER, 2 PERIODIC, 3 reserved).
REQ-012 The block SHALL have port o_busy, output, NCH bits: per-channel busy flag.
REQ-013 The block SHALL have port o_done, output, NCH bits: per-channel one-cycle expiry pulse.
REQ-014 The block SHALL have port o_any_busy, output, 1 bit: OR of all o_busy bits.

Function
REQ-015 Each channel SHALL hold a CW-bit counter cnt, a CW-bit amount register amt and a 2-bit mode register.
REQ-016 o_busy[k] SHALL equal (cnt[k] != 0) combinationally from the register; o_any_busy SHALL equal |o_busy.
REQ-017 Idle channel (cnt==0) with i_start[k]=1 and amt!=0 SHALL load cnt<=amt, so busy is high for exactly amt cycles starting the next cycle.
REQ-018 A start with amt==0 SHALL be ignored: no busy, no done.
REQ-019 While cnt!=0 and no load or abort occurs, cnt SHALL decrement by exactly 1 per cycle and never wrap below 0.
REQ-020 ONESHOT: i_start while busy SHALL be ignored.
REQ-021 RETRIGGER: i_start while busy SHALL reload cnt<=amt (busy extended, no done pulse).
REQ-022 PERIODIC: when cnt==1 and no abort, cnt SHALL reload to amt instead of 0; busy stays high until aborted.
REQ-023 Mode 3 SHALL behave exactly as ONESHOT.
REQ-024 o_done[k] SHALL be a register set for exactly one cycle in the cycle after any cycle where cnt[k]==1 and i_abort[k]==0, in all modes, including PERIODIC reloads; a RETRIGGER reload at cnt==1 SHALL suppress that pulse.
REQ-025 i_abort[k]=1 SHALL force cnt[k]<=0 next cycle with no o_done pulse; abort SHALL take priority over start, retrigger and periodic reload.
REQ-026 i_cfg_we=1 with i_cfg_ch<NCH SHALL write amt and mode of that channel next cycle; i_cfg_ch>=NCH SHALL be ignored.
REQ-027 A configuration write SHALL NOT alter a running cnt; the new amt/mode apply from the next cycle's decisions.
REQ-028 A start in the same cycle as a configuration write to that channel SHALL use the old amt and mode.
REQ-029 Channels SHALL be fully independent; simultaneous events on different channels SHALL not interact.

Reset
REQ-030 i_reset_n=0 SHALL asynchronously set all cnt=0, o_done=0, amt=DEFAULT_AMOUNT, mode=ONESHOT, hence o_busy=0 and o_any_busy=0.
REQ-031 Reset asserted mid-count SHALL clear the channel immediately with no o_done pulse; deassertion SHALL be synchronous to i_clk in the integrating design.

Verification
REQ-032 Bench SHALL check: reset, start ch0 (amt 22) -> o_busy[0] high exactly 22 cycles, o_done[0] single pulse on cycle 23.
REQ-033 Bench SHALL check: ch1 RETRIGGER amt 5, start at t0, start again at t3 -> busy 8 cycles total, exactly one o_done.
REQ-034 Bench SHALL check: ch2 PERIODIC amt 4, start held 1 cycle -> o_busy[2] continuously high, o_done[2] every 4 cycles; abort -> busy low next cycle, no done.
REQ-035 Bench SHALL check: ONESHOT start while busy ignored; amt 0 start -> no busy; cfg write to ch 7 with NCH=4 -> no state change.
REQ-036 Bench SHALL check: abort and start same cycle on idle channel -> stays idle; reset asserted at cnt=10 -> all outputs 0 immediately.
REQ-037 Formal harness SHALL assert: cnt!=0 implies o_busy; without load/abort cnt==$past(cnt)-1; o_done never high two consecutive cycles in ONESHOT.
